// File: rtl/regfile_writeback_if.sv
// Request, write-port and forwarding signals of the register-file write-back queue.
// The write-back block uses the slave view; the producer/decode side uses master.
interface regfile_writeback_if #(
    parameter int CW = 3
);
    logic          alu_valid;
    logic [4:0]    alu_rd;
    logic [31:0]   alu_data;
    logic          alu_ready;
    logic          mem_valid;
    logic [4:0]    mem_rd;
    logic [31:0]   mem_data;
    logic          mem_ready;
    logic          wb_we;
    logic [4:0]    wb_sel;
    logic [31:0]   wb_data;
    logic [4:0]    q_rs1;
    logic [4:0]    q_rs2;
    logic          fwd1_hit;
    logic [31:0]   fwd1_data;
    logic          fwd2_hit;
    logic [31:0]   fwd2_data;
    logic [CW-1:0] count;

    modport master (
        output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data, q_rs1, q_rs2,
        input  alu_ready, mem_ready, wb_we, wb_sel, wb_data,
               fwd1_hit, fwd1_data, fwd2_hit, fwd2_data, count
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data, q_rs1, q_rs2,
        output alu_ready, mem_ready, wb_we, wb_sel, wb_data,
               fwd1_hit, fwd1_data, fwd2_hit, fwd2_data, count
    );
endinterface

// File: rtl/regfile_writeback.sv
// Write-back queue: merges ALU and load register writes into one register-file
// write port through a small circular buffer, with forwarding of pending values.
module regfile_writeback #(
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input logic               clk,
    input logic               rst,
    regfile_writeback_if.slave bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef logic [PW-1:0] ptr_t;

    typedef struct packed {
        logic        hit;
        logic [31:0] data;
    } fwd_t;

    logic [4:0]    rd_mem   [DEPTH];
    logic [31:0]   data_mem [DEPTH];
    ptr_t          head;
    ptr_t          tail;
    logic [CW-1:0] count;
    logic          wb_we;
    logic [4:0]    wb_sel;
    logic [31:0]   wb_data;

    logic [CW:0]   free;
    logic          mem_ready;
    logic          alu_ready;
    logic          mem_push;
    logic          alu_push;
    logic          pop;
    logic [1:0]    n_push;
    fwd_t          fwd1;
    fwd_t          fwd2;

    // Credit comes only from registered occupancy; a same-edge pop frees nothing.
    assign free      = (CW+1)'(DEPTH) - {1'b0, count};
    assign mem_ready = !rst && (free >= (CW+1)'(1));
    assign alu_ready = !rst && ((free >= (CW+1)'(2)) ||
                                ((free >= (CW+1)'(1)) && !bus.mem_valid));

    // Writes to $zero complete the handshake but are dropped here.
    assign mem_push = bus.mem_valid && mem_ready && (bus.mem_rd != 5'd0);
    assign alu_push = bus.alu_valid && alu_ready && (bus.alu_rd != 5'd0);
    assign n_push   = {1'b0, mem_push} + {1'b0, alu_push};
    assign pop      = (count != '0);

    // NOTE: queue storage carries no reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (mem_push) begin
            rd_mem[tail]   <= bus.mem_rd;
            data_mem[tail] <= bus.mem_data;
        end
        if (alu_push) begin
            rd_mem[tail + ptr_t'(mem_push)]   <= bus.alu_rd;
            data_mem[tail + ptr_t'(mem_push)] <= bus.alu_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            wb_we   <= 1'b0;
            wb_sel  <= '0;
            wb_data <= '0;
        end else begin
            if (pop) begin
                wb_we   <= 1'b1;
                wb_sel  <= rd_mem[head];
                wb_data <= data_mem[head];
                head    <= head + ptr_t'(1);
            end else begin
                wb_we   <= 1'b0;
            end
            tail  <= tail + ptr_t'(n_push);
            count <= count + CW'(n_push) - CW'(pop);
        end
    end

    // Oldest first: the presented wb entry, then head..tail, so later hits win.
    function automatic fwd_t lookup(input logic [4:0] sel);
        fwd_t r;
        ptr_t idx;
        r = '0;
        if (wb_we && (wb_sel == sel)) begin
            r.hit  = 1'b1;
            r.data = wb_data;
        end
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + ptr_t'(i);
            if ((CW'(i) < count) && (rd_mem[idx] == sel)) begin
                r.hit  = 1'b1;
                r.data = data_mem[idx];
            end
        end
        if (sel == 5'd0) begin
            r = '0;
        end
        return r;
    endfunction

    // NOTE: every always_comb output is assigned on all paths to avoid latches.
    always_comb begin
        fwd1 = lookup(bus.q_rs1);
        fwd2 = lookup(bus.q_rs2);
    end

    assign bus.alu_ready = alu_ready;
    assign bus.mem_ready = mem_ready;
    assign bus.wb_we     = wb_we;
    assign bus.wb_sel    = wb_sel;
    assign bus.wb_data   = wb_data;
    assign bus.fwd1_hit  = fwd1.hit;
    assign bus.fwd1_data = fwd1.data;
    assign bus.fwd2_hit  = fwd2.hit;
    assign bus.fwd2_data = fwd2.data;
    assign bus.count     = count;
endmodule

// File: tb/tb_regfile_writeback.sv
// Randomized and directed bench for regfile_writeback against a queue-based
// model of pending writes and the presented write-port entry.
module tb_regfile_writeback;
    localparam int DEPTH = 4;
    localparam int CW    = 3;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    regfile_writeback_if #(.CW(CW)) bus ();

    regfile_writeback #(.DEPTH(DEPTH), .CW(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;

    wr_t         pend[$];
    logic        m_we;
    logic [4:0]  m_sel;
    logic [31:0] m_data;
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic void lookup(input logic [4:0] sel, output logic hit, output logic [31:0] data);
        hit  = 1'b0;
        data = '0;
        if (sel == 5'd0) return;
        if (m_we && m_sel == sel) begin
            hit  = 1'b1;
            data = m_data;
        end
        foreach (pend[i]) begin
            if (pend[i].rd == sel) begin
                hit  = 1'b1;
                data = pend[i].data;
            end
        end
    endfunction

    task automatic cycle(input logic r,
                         input logic av, input logic [4:0] ard, input logic [31:0] ad,
                         input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                         input logic [4:0] s1, input logic [4:0] s2);
        int          free;
        logic        e_mr, e_ar, h1, h2;
        logic [31:0] d1, d2;
        wr_t         w;
        @(negedge clk);
        rst           = r;
        bus.alu_valid = av;
        bus.alu_rd    = ard;
        bus.alu_data  = ad;
        bus.mem_valid = mv;
        bus.mem_rd    = mrd;
        bus.mem_data  = md;
        bus.q_rs1     = s1;
        bus.q_rs2     = s2;
        #1;
        free = DEPTH - pend.size();
        e_mr = !r && (free >= 1);
        e_ar = !r && ((free >= 2) || ((free >= 1) && !mv));
        lookup(s1, h1, d1);
        lookup(s2, h2, d2);
        check("mem_ready", bus.mem_ready, e_mr);
        check("alu_ready", bus.alu_ready, e_ar);
        check("count",     bus.count,     pend.size());
        check("wb_we",     bus.wb_we,     m_we);
        check("wb_sel",    bus.wb_sel,    m_sel);
        check("wb_data",   bus.wb_data,   m_data);
        check("fwd1_hit",  bus.fwd1_hit,  h1);
        check("fwd1_data", bus.fwd1_data, d1);
        check("fwd2_hit",  bus.fwd2_hit,  h2);
        check("fwd2_data", bus.fwd2_data, d2);
        @(posedge clk);
        if (r) begin
            pend.delete();
            m_we   = 1'b0;
            m_sel  = '0;
            m_data = '0;
        end else begin
            if (pend.size() > 0) begin
                w      = pend.pop_front();
                m_we   = 1'b1;
                m_sel  = w.rd;
                m_data = w.data;
            end else begin
                m_we = 1'b0;
            end
            if (mv && e_mr && mrd != 5'd0) pend.push_back('{mrd, md});
            if (av && e_ar && ard != 5'd0) pend.push_back('{ard, ad});
        end
    endtask

    task automatic idle(input int n, input logic [4:0] s1);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, s1, 5'd0);
    endtask

    initial begin
        rst = 1'b1;
        bus.alu_valid = 1'b0; bus.alu_rd = '0; bus.alu_data = '0;
        bus.mem_valid = 1'b0; bus.mem_rd = '0; bus.mem_data = '0;
        bus.q_rs1 = '0; bus.q_rs2 = '0;
        m_we = 1'b0; m_sel = '0; m_data = '0;
        repeat (2) @(posedge clk);

        // Reset state, then a single ALU write to r8.
        cycle(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd8, 5'd0);
        cycle(1'b0, 1'b1, 5'd8, 32'h0000_1234, 1'b0, 5'd0, 32'd0, 5'd8, 5'd0);
        cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd8, 5'd0);
        #1;
        check("t1_wb_we",   bus.wb_we,   1'b1);
        check("t1_wb_sel",  bus.wb_sel,  5'd8);
        check("t1_wb_data", bus.wb_data, 32'h0000_1234);
        check("t1_count",   bus.count,   3'd0);
        idle(2, 5'd8);

        // Same-edge mem and alu to r9: mem is older, alu wins forwarding.
        cycle(1'b0, 1'b1, 5'd9, 32'h5555_0000, 1'b1, 5'd9, 32'hAAAA_0000, 5'd9, 5'd9);
        #1;
        check("t2_count", bus.count, 3'd2);
        check("t2_fwd1",  bus.fwd1_data, 32'h5555_0000);
        idle(4, 5'd9);

        // Fill with both valid held; alu backs off once only one slot is free.
        for (int i = 0; i < 4; i++)
            cycle(1'b0, 1'b1, 5'(10 + 2*i), 32'h100 + i, 1'b1, 5'(11 + 2*i), 32'h200 + i, 5'd11, 5'd12);
        #1;
        check("fill_count",     bus.count,     3'd3);
        check("fill_alu_ready", bus.alu_ready, 1'b0);
        check("fill_mem_ready", bus.mem_ready, 1'b1);
        idle(5, 5'd15);

        // Writes to $zero are accepted and dropped.
        cycle(1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        #1;
        check("zero_count", bus.count, 3'd0);
        idle(3, 5'd0);

        // Two pending writes to r3 observed through drain.
        cycle(1'b0, 1'b1, 5'd3, 32'h22, 1'b1, 5'd3, 32'h11, 5'd3, 5'd3);
        idle(4, 5'd3);

        // Reset with entries queued discards them.
        for (int i = 0; i < 3; i++)
            cycle(1'b0, 1'b1, 5'(20 + i), 32'hC0 + i, 1'b1, 5'(24 + i), 32'hD0 + i, 5'd20, 5'd24);
        cycle(1'b1, 1'b1, 5'd5, 32'h5, 1'b1, 5'd6, 32'h6, 5'd20, 5'd24);
        #1;
        check("rst_count", bus.count, 3'd0);
        check("rst_wb_we", bus.wb_we, 1'b0);
        idle(4, 5'd20);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 2000; i++) begin
            cycle(($urandom_range(0, 63) == 0),
                  ($urandom_range(0, 9) < 6), 5'($urandom_range(0, 7)), $urandom(),
                  ($urandom_range(0, 9) < 6), 5'($urandom_range(0, 7)), $urandom(),
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        end
        idle(6, 5'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
